// File: rtl/pc_seq_pkg.sv
// Shared types, default addresses and the fetch-address legality check for the PC sequencer.
package pc_seq_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEFAULT     = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE_DEFAULT  = 32'h0000_3000;
  localparam int unsigned IMEM_WORDS_DEFAULT = 4096;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } seq_state_e;

  // Numeric order doubles as redirect priority: eret beats br beats nothing.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_ERET = 2'd2
  } pend_src_e;

  // Word-aligned and inside [base, base + 4*words); the limit is widened so it cannot wrap.
  function automatic logic pc_legal(input logic [31:0] pc,
                                    input logic [31:0] base,
                                    input logic [31:0] words);
    logic [33:0] limit;
    limit = {2'b00, base} + {words, 2'b00};
    return (pc[1:0] == 2'b00) && (pc >= base) && ({2'b00, pc} < limit);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect/stall inputs and fetch-PC outputs of the PC sequencer, bundled as one interface.
interface pc_sequencer_if;

  logic        stall_i;
  logic        br_valid_i;
  logic [31:0] br_target_i;
  logic        eret_valid_i;
  logic [31:0] epc_i;
  logic        exc_valid_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        addr_err_o;
  logic [31:0] fetch_cnt_o;

  // Driver side: hazard unit / D-stage / exception logic.
  modport master (
    output stall_i, br_valid_i, br_target_i, eret_valid_i, epc_i, exc_valid_i,
    input  pc_o, pc_valid_o, addr_err_o, fetch_cnt_o
  );

  // Sequencer side.
  modport slave (
    input  stall_i, br_valid_i, br_target_i, eret_valid_i, epc_i, exc_valid_i,
    output pc_o, pc_valid_o, addr_err_o, fetch_cnt_o
  );

endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer holding a redirect that arrived while fetch was stalled.
module pc_redirect_buf
  import pc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  pend_src_e   load_src_i,
  input  logic [31:0] load_target_i,
  input  logic        clear_i,
  output logic        valid_o,
  output logic [31:0] target_o
);

  logic        valid_q, valid_d;
  pend_src_e   src_q, src_d;
  logic [31:0] target_q, target_d;
  logic        load_ok;

  // An empty buffer reads as SRC_NONE, so any real source wins the compare.
  assign load_ok = (load_src_i != SRC_NONE) && (load_src_i >= src_q);

  always_comb begin
    valid_d  = valid_q;
    src_d    = src_q;
    target_d = target_q;
    if (clear_i) begin
      valid_d = 1'b0;
      src_d   = SRC_NONE;
    end else if (load_i && load_ok) begin
      valid_d  = 1'b1;
      src_d    = load_src_i;
      target_d = load_target_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      src_q    <= SRC_NONE;
      target_q <= 32'h0;
    end else begin
      valid_q  <= valid_d;
      src_q    <= src_d;
      target_q <= target_d;
    end
  end

  assign valid_o  = valid_q;
  assign target_o = target_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program-counter controller: next-PC arbitration, stall hold and pending redirect.
// Build option PC_SEQ_TRACE_EN enables the saturating fetch_cnt_o advance counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_PC     = EXC_PC_DEFAULT,
  parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEFAULT,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  pc_sequencer_if.slave bus
);

  localparam logic [31:0] WORDS = 32'(IMEM_WORDS);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        addr_err_q, addr_err_d;

  logic        pend_valid;
  logic [31:0] pend_target;
  logic        buf_load, buf_clear;
  pend_src_e   buf_load_src;
  logic [31:0] buf_load_target;

  logic        redir_valid;
  logic [31:0] redir_target;
  logic        redir_legal;

  pc_redirect_buf u_buf (
    .clk           (clk),
    .reset_n       (reset_n),
    .load_i        (buf_load),
    .load_src_i    (buf_load_src),
    .load_target_i (buf_load_target),
    .clear_i       (buf_clear),
    .valid_o       (pend_valid),
    .target_o      (pend_target)
  );

  // Redirect candidate for an unstalled cycle: eret > br > pending.
  always_comb begin
    redir_valid  = bus.eret_valid_i | bus.br_valid_i | pend_valid;
    redir_target = pend_target;
    if (bus.eret_valid_i) begin
      redir_target = bus.epc_i;
    end else if (bus.br_valid_i) begin
      redir_target = bus.br_target_i;
    end
    redir_legal = pc_legal(redir_target, IMEM_BASE, WORDS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_err_q <= addr_err_d;
    end
  end

  // HOLD persists while stalled; a stalled redirect in RUN enters it; exc always leaves it.
  always_comb begin
    state_d = ST_RUN;
    if (!bus.exc_valid_i && bus.stall_i &&
        (state_q == ST_HOLD || bus.eret_valid_i || bus.br_valid_i)) begin
      state_d = ST_HOLD;
    end
  end

  always_comb begin
    pc_d            = pc_q;
    addr_err_d      = 1'b0;
    buf_load        = 1'b0;
    buf_clear       = 1'b0;
    buf_load_src    = bus.eret_valid_i ? SRC_ERET : SRC_BR;
    buf_load_target = bus.eret_valid_i ? bus.epc_i : bus.br_target_i;
    if (bus.exc_valid_i) begin
      pc_d      = EXC_PC;
      buf_clear = 1'b1;
    end else if (!bus.stall_i) begin
      buf_clear = 1'b1;
      if (redir_valid) begin
        if (redir_legal) begin
          pc_d = redir_target;
        end else begin
          pc_d       = EXC_PC;
          addr_err_d = 1'b1;
        end
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else begin
      buf_load = bus.eret_valid_i | bus.br_valid_i;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_valid_o = pc_legal(pc_q, IMEM_BASE, WORDS);
  assign bus.addr_err_o = addr_err_q;

`ifdef PC_SEQ_TRACE_EN
  logic        advance;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // Every unstalled edge and every exception reloads pc_o.
  assign advance = bus.exc_valid_i | ~bus.stall_i;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (advance && fetch_cnt_q != 32'hFFFF_FFFF) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign bus.fetch_cnt_o = fetch_cnt_q;
`else
  assign bus.fetch_cnt_o = 32'h0;
`endif

endmodule
